// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter with burst lock in front of a single-port data memory.
//   clk, rst_n                    clock, asynchronous active-low reset
//   req/we/addr/wdata/lock{0,1}   requester access and lock request
//   gnt{0,1}                      combinational grant
//   rvalid/rdata{0,1}             read return one cycle after grant
//   dm_we/dm_address/dm_d/dm_q    single-port memory side
module dm_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_d,
    input  logic [DATA_W-1:0] dm_q
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    state_t          r_state;
    logic            r_last;
    logic [CW-1:0]   r_cnt;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            w_own0;
    logic            w_own1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [CW-1:0]   w_cnt_nx;
    logic            w_lock_end;
    // a locked owner that is still requesting beats any round-robin decision
    assign w_own0     = (r_state == LOCK0) & req0;
    assign w_own1     = (r_state == LOCK1) & req1;
    assign w_gnt0     = rst_n & (w_own0 | (~w_own1 & req0 & (~req1 | r_last)));
    assign w_gnt1     = rst_n & (w_own1 | (~w_own0 & req1 & (~req0 | ~r_last)));
    assign w_cnt_nx   = r_cnt + 1'b1;
    assign w_lock_end = w_cnt_nx == CW'(MAX_LOCK);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            if (w_own0 | w_own1) begin
                r_cnt <= w_cnt_nx;
                if (~(w_own0 ? lock0 : lock1) | w_lock_end) begin
                    r_state <= ARB;
                    r_last  <= w_own1;
                end
            end else if (w_gnt0 | w_gnt1) begin
                r_last  <= w_gnt1;
                r_cnt   <= CW'(1);
                r_state <= (MAX_LOCK > 1 && w_gnt0 && lock0) ? LOCK0 :
                           (MAX_LOCK > 1 && w_gnt1 && lock1) ? LOCK1 : ARB;
            end else begin
                r_state <= ARB;
            end
        end
    end
    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata0     = r_rvalid0 ? dm_q : '0;
    assign rdata1     = r_rvalid1 ? dm_q : '0;
    assign dm_we      = w_gnt0 ? we0 : (w_gnt1 & we1);
    assign dm_address = w_gnt0 ? addr0 : w_gnt1 ? addr1 : '0;
    assign dm_d       = w_gnt0 ? wdata0 : w_gnt1 ? wdata1 : '0;
endmodule
